// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 adder/subtractor (align, add+LZC, normalize/round/pack)
// under a valid/ready handshake with flush and an in-order tag sideband.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic [2:0]           in_rm,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_res,
    output logic [4:0]           out_flags,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned SW  = MAN_W + 4;
    localparam int unsigned LZW = $clog2(SW + 1);

    localparam logic [2:0]       RM_RNE = 3'd0;
    localparam logic [2:0]       RM_RTZ = 3'd1;
    localparam logic [2:0]       RM_RDN = 3'd2;
    localparam logic [2:0]       RM_RUP = 3'd3;
    localparam logic [2:0]       RM_RMM = 3'd4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    // Pipeline advances as a unit; only a valid, unaccepted result holds it.
    logic stall;
    logic out_valid_q;
    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall & ~flush;

    // Operand decode
    logic             sa, sb, a_zx, b_zx, a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
    logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff;
    logic [MAN_W-1:0] fa, fb;
    logic [SW-1:0]    siga, sigb;

    assign sa     = in_a[W-1];
    assign ea     = in_a[W-2:MAN_W];
    assign fa     = in_a[MAN_W-1:0];
    assign sb     = in_b[W-1] ^ in_sub;
    assign eb     = in_b[W-2:MAN_W];
    assign fb     = in_b[MAN_W-1:0];
    assign a_zx   = ~|ea;
    assign b_zx   = ~|eb;
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    assign a_snan = a_nan & ~fa[MAN_W-1];
    assign b_snan = b_nan & ~fb[MAN_W-1];
    assign ea_eff = a_zx ? EXP_W'(1) : ea;
    assign eb_eff = b_zx ? EXP_W'(1) : eb;
    assign siga   = {~a_zx, fa, 3'b000};
    assign sigb   = {~b_zx, fb, 3'b000};
    assign swap   = {eb, fb} > {ea, fa};

    // S1: swap, align with sticky, resolve special operands
    logic             v1_q, sgn1_q, sgn1_d, sub1_q, sub1_d, zs1_q, zs1_d;
    logic             spec1_q, spec1_d, nv1_q, nv1_d;
    logic [EXP_W-1:0] exp1_q, exp1_d, e_sml, e_diff;
    logic [SW-1:0]    siga1_q, siga1_d, sigb1_q, sigb1_d, sig_sml;
    logic [W-1:0]     specres1_q, specres1_d;
    logic [2:0]       rm1_q, rm1_d;
    logic [TAG_W-1:0] tag1_q;

    always_comb begin
        sgn1_d  = swap ? sb : sa;
        sub1_d  = sa ^ sb;
        exp1_d  = swap ? eb_eff : ea_eff;
        e_sml   = swap ? ea_eff : eb_eff;
        siga1_d = swap ? sigb : siga;
        sig_sml = swap ? siga : sigb;
        e_diff  = exp1_d - e_sml;
        sigb1_d = sig_sml >> e_diff;
        sigb1_d[0] = sigb1_d[0] | (|(sig_sml & ~({SW{1'b1}} << e_diff)));
        if (32'(e_diff) >= 32'(SW - 1))
            sigb1_d = {{(SW-1){1'b0}}, |sig_sml};
        rm1_d   = (in_rm > RM_RMM) ? RM_RNE : in_rm;
        zs1_d   = (sa == sb) ? sa : (rm1_d == RM_RDN);
        spec1_d = a_nan | b_nan | a_inf | b_inf;
        nv1_d   = a_snan | b_snan | (a_inf & b_inf & (sa ^ sb));
        if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb)))
            specres1_d = QNAN;
        else if (a_inf)
            specres1_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        else
            specres1_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end

    // S2: significand add/subtract and leading-zero count
    logic             v2_q, sgn2_q, zs2_q, spec2_q, nv2_q;
    logic [EXP_W-1:0] exp2_q;
    logic [SW:0]      sum2_q, sum2_d;
    logic [LZW-1:0]   lzc2_q, lzc2_d;
    logic [W-1:0]     specres2_q;
    logic [2:0]       rm2_q;
    logic [TAG_W-1:0] tag2_q;

    always_comb begin
        if (sub1_q) sum2_d = {1'b0, siga1_q} - {1'b0, sigb1_q};
        else        sum2_d = {1'b0, siga1_q} + {1'b0, sigb1_q};
        lzc2_d = LZW'(SW);
        for (int i = 0; i < int'(SW); i++)
            if (sum2_d[i]) lzc2_d = LZW'(int'(SW) - 1 - i);
    end

    // S3: normalize, round, detect overflow/tininess, pack
    logic [SW-1:0]    nsig;
    logic [EXP_W:0]   nexp, fexp;
    logic [LZW-1:0]   sh;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac;
    logic             nx, inc, inf_sel;
    logic [W-1:0]     res_q, res_d;
    logic [4:0]       flg_q, flg_d;
    logic [TAG_W-1:0] tag3_q;

    always_comb begin
        sh = '0;
        if (sum2_q[SW]) begin
            nsig = {sum2_q[SW:2], sum2_q[1] | sum2_q[0]};
            nexp = {1'b0, exp2_q} + (EXP_W+1)'(1);
        end else begin
            if (32'(lzc2_q) < 32'(exp2_q)) sh = lzc2_q;
            else                           sh = LZW'(exp2_q - EXP_W'(1));
            nsig = sum2_q[SW-1:0] << sh;
            nexp = {1'b0, exp2_q} - (EXP_W+1)'(sh);
        end
        nx = |nsig[2:0];
        case (rm2_q)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sgn2_q & nx;
            RM_RUP:  inc = ~sgn2_q & nx;
            RM_RMM:  inc = nsig[2];
            default: inc = nsig[2] & (nsig[1] | nsig[0] | nsig[3]);
        endcase
        mant_r = {1'b0, nsig[SW-1:3]} + (MAN_W+2)'(inc);
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        if (mant_r[MAN_W+1])   fexp = nexp + (EXP_W+1)'(1);
        else if (mant_r[MAN_W]) fexp = nexp;
        else                    fexp = '0;
        frac    = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        inf_sel = (rm2_q == RM_RNE) | (rm2_q == RM_RMM) |
                  ((rm2_q == RM_RUP) & ~sgn2_q) | ((rm2_q == RM_RDN) & sgn2_q);
        if (spec2_q) begin
            res_d = specres2_q;
            flg_d = {nv2_q, 4'b0000};
        end else if (sum2_q == '0) begin
            res_d = {zs2_q, {(W-1){1'b0}}};
            flg_d = 5'b00000;
        end else if (fexp >= {1'b0, EXP_ONES}) begin
            res_d = inf_sel ? {sgn2_q, EXP_ONES, {MAN_W{1'b0}}}
                            : {sgn2_q, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
            flg_d = 5'b00101;
        end else begin
            res_d = {sgn2_q, fexp[EXP_W-1:0], frac};
            flg_d = {3'b000, ~nsig[SW-1] & nx, nx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; sgn1_q <= 1'b0; sub1_q <= 1'b0; zs1_q <= 1'b0;
            spec1_q <= 1'b0; nv1_q <= 1'b0; exp1_q <= '0; siga1_q <= '0; sigb1_q <= '0;
            specres1_q <= '0; rm1_q <= '0; tag1_q <= '0;
            v2_q <= 1'b0; sgn2_q <= 1'b0; zs2_q <= 1'b0; spec2_q <= 1'b0; nv2_q <= 1'b0;
            exp2_q <= '0; sum2_q <= '0; lzc2_q <= '0; specres2_q <= '0; rm2_q <= '0;
            tag2_q <= '0;
            out_valid_q <= 1'b0; res_q <= '0; flg_q <= '0; tag3_q <= '0;
        end else if (!stall) begin
            v1_q <= in_valid & in_ready;
            sgn1_q <= sgn1_d; sub1_q <= sub1_d; zs1_q <= zs1_d; spec1_q <= spec1_d;
            nv1_q <= nv1_d; exp1_q <= exp1_d; siga1_q <= siga1_d; sigb1_q <= sigb1_d;
            specres1_q <= specres1_d; rm1_q <= rm1_d; tag1_q <= in_tag;
            v2_q <= v1_q & ~flush;
            sgn2_q <= sgn1_q; zs2_q <= zs1_q; spec2_q <= spec1_q; nv2_q <= nv1_q;
            exp2_q <= exp1_q; sum2_q <= sum2_d; lzc2_q <= lzc2_d;
            specres2_q <= specres1_q; rm2_q <= rm1_q; tag2_q <= tag1_q;
            out_valid_q <= v2_q & ~flush;
            res_q <= res_d; flg_q <= flg_d; tag3_q <= tag2_q;
        end else if (flush) begin
            v1_q <= 1'b0; v2_q <= 1'b0; out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = res_q;
    assign out_flags = flg_q;
    assign out_tag   = tag3_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: directed corner cases, back-pressure, flush, reset, and a random
// stream checked against an exact-integer reference of the FP32 add/sub.
module tb_fp_addsub_pipe;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned W     = 32;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [W-1:0]     in_a, in_b, out_res;
    logic [2:0]       in_rm;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [4:0]       out_flags;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [4:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass = 0, n_checks = 0, n_out = 0;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_flags(out_flags), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] req);
        n_checks++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, req);
    endtask

    // Exact reference: operands become integers in units of 2^-149, then rounded to FP32.
    function automatic logic [36:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic [2:0] rm);
        logic         sa, sb, sgn, an, bn, ai, bi, inc, nx;
        logic [7:0]   ea, eb;
        logic [22:0]  fa, fb;
        logic [299:0] na, nb, n, kept, rem, half, one;
        logic [2:0]   m;
        int           p, sh;
        m  = (rm > 3'd4) ? 3'd0 : rm;
        sa = a[31]; ea = a[30:23]; fa = a[22:0];
        sb = b[31] ^ sub; eb = b[30:23]; fb = b[22:0];
        an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
        if (an || bn)
            return {((an && !fa[22]) || (bn && !fb[22])) ? 5'b10000 : 5'b00000, 32'h7FC00000};
        if (ai && bi && (sa != sb)) return {5'b10000, 32'h7FC00000};
        if (ai) return {5'b0, sa, 8'hFF, 23'h0};
        if (bi) return {5'b0, sb, 8'hFF, 23'h0};
        one = 300'd1;
        na = 300'({ea != 0, fa}) << ((ea == 0) ? 0 : int'(ea) - 1);
        nb = 300'({eb != 0, fb}) << ((eb == 0) ? 0 : int'(eb) - 1);
        if (sa == sb)     begin n = na + nb; sgn = sa; end
        else if (na >= nb) begin n = na - nb; sgn = sa; end
        else               begin n = nb - na; sgn = sb; end
        if (n == 0) return {5'b0, (sa == sb) ? sa : (m == 3'd2), 31'h0};
        p = 0;
        for (int i = 0; i < 300; i++) if (n[i]) p = i;
        if (p <= 23) return {5'b0, sgn, n[30:0]};
        sh   = p - 23;
        kept = n >> sh;
        rem  = n & ((one << sh) - one);
        half = one << (sh - 1);
        nx   = (rem != 0);
        case (m)
            3'd1:    inc = 1'b0;
            3'd2:    inc = sgn & nx;
            3'd3:    inc = !sgn & nx;
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && kept[0]);
        endcase
        kept = kept + 300'(inc);
        if (kept[24]) begin kept = kept >> 1; sh++; end
        if (sh + 1 >= 255) begin
            if (m == 3'd0 || m == 3'd4 || (m == 3'd3 && !sgn) || (m == 3'd2 && sgn))
                return {5'b00101, sgn, 8'hFF, 23'h0};
            return {5'b00101, sgn, 8'hFE, 23'h7FFFFF};
        end
        return {4'b0000, nx, sgn, 8'(sh + 1), kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0: r[30:0] = 31'h0;
            1: begin r[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) r[22:0] = 23'h0; end
            2: r[30:23] = 8'h00;
            3: r[30:23] = 8'hFE;
            4: r[30:23] = 8'($urandom_range(1, 254));
            default: r[30:23] = 8'(120 + $urandom_range(0, 16));
        endcase
        return r;
    endfunction

    // One cycle: drive at the falling edge, check output vs scoreboard, record acceptance.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [2:0] rm, input logic [4:0] tag,
                        input logic ordy, input logic fl, input logic has_exp,
                        input logic [36:0] dexp, output logic acc);
        exp_t e;
        logic [36:0] r;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_sub = sub; in_rm = rm; in_tag = tag;
        out_ready = ordy; flush = fl;
        #1;
        if (sb_q.size() == 0) begin
            check("idle_valid", 64'(out_valid), 64'd0);
        end else if (out_valid) begin
            check("res", 64'(out_res), 64'(sb_q[0].res));
            check("flags", 64'(out_flags), 64'(sb_q[0].flags));
            check("tag", 64'(out_tag), 64'(sb_q[0].tag));
            if (out_ready) begin void'(sb_q.pop_front()); n_out++; end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            r = has_exp ? dexp : ref_add(a, b, sub, rm);
            e.res = r[31:0]; e.flags = r[36:32]; e.tag = tag;
            sb_q.push_back(e);
        end
        if (fl) sb_q.delete();
    endtask

    initial begin
        logic acc;
        logic [36:0] none;
        int k, n0;
        none = '0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_rm = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_res", 64'(out_res), 64'd0);
        check("rst_out_flags", 64'(out_flags), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency: accepted in cycle 0, visible in cycle 3
        step(1, 32'h3F800000, 32'h40000000, 0, 3'd0, 5'd5, 1, 0, 1, {5'b0, 32'h40400000}, acc);
        check("lat_acc", 64'(acc), 64'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);
        check("lat_c1", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);
        check("lat_c2", 64'(out_valid), 64'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);
        check("lat_c3", 64'(out_valid), 64'd1);

        // Directed corner cases, issued back-to-back
        step(1, 32'h3F800000, 32'h3F800000, 1, 3'd0, 5'd1, 1, 0, 1, {5'h00, 32'h00000000}, acc);
        step(1, 32'h3F800000, 32'h3F800000, 1, 3'd2, 5'd2, 1, 0, 1, {5'h00, 32'h80000000}, acc);
        step(1, 32'h7F800000, 32'h7F800000, 1, 3'd0, 5'd3, 1, 0, 1, {5'h10, 32'h7FC00000}, acc);
        step(1, 32'h7FA00000, 32'h3F800000, 0, 3'd0, 5'd4, 1, 0, 1, {5'h10, 32'h7FC00000}, acc);
        step(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd0, 5'd5, 1, 0, 1, {5'h05, 32'h7F800000}, acc);
        step(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 3'd1, 5'd6, 1, 0, 1, {5'h05, 32'h7F7FFFFF}, acc);
        step(1, 32'h3F800000, 32'h33800000, 0, 3'd0, 5'd7, 1, 0, 1, {5'h01, 32'h3F800000}, acc);
        step(1, 32'h3F800000, 32'h33800000, 0, 3'd3, 5'd8, 1, 0, 1, {5'h01, 32'h3F800001}, acc);
        step(1, 32'h3F800000, 32'h33800000, 0, 3'd4, 5'd9, 1, 0, 1, {5'h01, 32'h3F800001}, acc);
        step(1, 32'h00800000, 32'h00400001, 1, 3'd0, 5'd10, 1, 0, 1, {5'h00, 32'h003FFFFF}, acc);
        step(1, 32'h80000000, 32'h80000000, 0, 3'd0, 5'd11, 1, 0, 1, {5'h00, 32'h80000000}, acc);
        step(1, 32'h00000000, 32'h00000000, 0, 3'd0, 5'd12, 1, 0, 1, {5'h00, 32'h00000000}, acc);
        repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);
        check("dir_drain", 64'(sb_q.size()), 64'd0);

        // Back-pressure: 6 ops, consumer stalls cycles 2..8
        n0 = n_out; k = 0;
        for (int c = 0; c < 40 && (k < 6 || sb_q.size() != 0); c++) begin
            step(k < 6, 32'h3F800000 + 32'(k), 32'h40000000, 0, 3'd0, 5'(16 + k),
                 !(c >= 2 && c <= 8), 0, 0, none, acc);
            if (c == 2) check("bp_rdy_c2", 64'(in_ready), 64'd1);
            if (c == 3) check("bp_rdy_c3", 64'(in_ready), 64'd0);
            if (acc) k++;
        end
        check("bp_issued", 64'(k), 64'd6);
        check("bp_count", 64'(n_out - n0), 64'd6);

        // Flush kills in-flight ops; the op offered with flush is refused
        n0 = n_out;
        for (int i = 0; i < 3; i++)
            step(1, rand_op(), rand_op(), 0, 3'd0, 5'(i), 1, 0, 0, none, acc);
        step(1, 32'h3F800000, 32'h3F800000, 0, 3'd0, 5'd30, 1, 1, 0, none, acc);
        check("flush_rdy", 64'(in_ready), 64'd0);
        check("flush_acc", 64'(acc), 64'd0);
        repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);
        check("flush_count", 64'(n_out - n0), 64'd1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++)
            step(1, rand_op(), rand_op(), 1, 3'd0, 5'(i), 0, 0, 0, none, acc);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1 check("rst_mid_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_rel_ready", 64'(in_ready), 64'd1);
        repeat (6) step(0, 0, 0, 0, 0, 0, 1, 0, 0, none, acc);

        // Random stream with random back-pressure
        k = 0;
        for (int c = 0; c < 4000 && (k < 400 || sb_q.size() != 0); c++) begin
            logic [31:0] ra, rb;
            ra = rand_op();
            rb = ($urandom_range(0, 3) == 0) ? (ra ^ 32'($urandom_range(0, 7))) : rand_op();
            step((k < 400) && ($urandom_range(0, 3) != 0), ra, rb, 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 5'(k), $urandom_range(0, 3) != 0, 0, 0, none, acc);
            if (acc) k++;
        end
        check("rand_issued", 64'(k), 64'd400);
        check("rand_drain", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
